// File: rtl/mem_read_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_read_pipe_pkg
// Brief   : Shared constants and pipeline entry type for mem_read_pipe.
// Rev     : 1.0 - initial release
// ============================================================================
package mem_read_pipe_pkg;

    localparam int WORD_W          = 16;
    localparam int DEFAULT_LATENCY = 4;
    localparam int BLOCK_WORDS     = 8;

    typedef struct packed {
        logic              valid;
        logic [15:0]       addr;
        logic [WORD_W-1:0] data;
    } pipe_entry_t;

    function automatic logic [15:0] word_align(input logic [15:0] byte_addr);
        return {byte_addr[15:1], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_read_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_read_pipe_if
// Brief     : Request/response bundle between the fill FSM and memory model.
// Rev       : 1.0 - initial release
// ============================================================================
interface mem_read_pipe_if;
    import mem_read_pipe_pkg::*;

    logic              enable;
    logic              wr;
    logic [15:0]       addr;
    logic [WORD_W-1:0] data_in;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic [15:0]       addr_out;
    logic [3:0]        pending;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, addr_out, pending
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, addr_out, pending
    );
endinterface
`default_nettype wire

// File: rtl/mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_pipe_stage
// Brief  : One valid/addr/data delay-line register. With MEM_WR_FWD_EN a
//          matching write overwrites the data of the entry passing through.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_pipe_stage
    import mem_read_pipe_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  pipe_entry_t       entry_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    output pipe_entry_t       entry_out
);

    pipe_entry_t r_entry;
    logic        w_hit;

`ifdef MEM_WR_FWD_EN
    assign w_hit = wr_en && entry_in.valid && (entry_in.addr[ADDR_W:1] == wr_idx);
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{wr_en, wr_idx, wr_data};
    assign w_hit        = 1'b0;
`endif

    // Payload only moves with a valid entry, so the last stage holds the
    // most recently delivered word while the pipe is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_entry <= '0;
        end else begin
            r_entry.valid <= entry_in.valid;
            if (entry_in.valid) begin
                r_entry.addr <= entry_in.addr;
                r_entry.data <= w_hit ? wr_data : entry_in.data;
            end
        end
    end

    assign entry_out = r_entry;

endmodule
`default_nettype wire

// File: rtl/mem_read_pipe.sv
`default_nettype none
// ============================================================================
// Module : mem_read_pipe
// Brief  : Word-addressed main-memory model with a fixed-latency read pipe.
//          Optional in-flight write forwarding via MEM_WR_FWD_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_read_pipe
    import mem_read_pipe_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic            clk,
    input  logic            rst,
    mem_read_pipe_if.slave  bus
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];
    logic [3:0]        r_pending;
    logic              w_rd;
    logic              w_wr;
    logic [ADDR_W-1:0] w_idx;
    logic              w_unused_addr0;
    pipe_entry_t       w_pipe [LATENCY+1];

    assign w_rd           = bus.enable & ~bus.wr;
    assign w_wr           = bus.enable &  bus.wr;
    assign w_idx          = bus.addr[ADDR_W:1];
    assign w_unused_addr0 = bus.addr[0];

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= bus.data_in;
        end
    end

    assign w_pipe[0] = '{valid: w_rd, addr: word_align(bus.addr), data: r_mem[w_idx]};

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        mem_pipe_stage #(
            .ADDR_W    (ADDR_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .entry_in  (w_pipe[g]),
            .wr_en     (w_wr),
            .wr_idx    (w_idx),
            .wr_data   (bus.data_in),
            .entry_out (w_pipe[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 4'd0;
        end else begin
            r_pending <= r_pending + {3'b000, w_rd} - {3'b000, w_pipe[LATENCY].valid};
        end
    end

    assign bus.data_valid = w_pipe[LATENCY].valid;
    assign bus.data_out   = w_pipe[LATENCY].data;
    assign bus.addr_out   = w_pipe[LATENCY].addr;
    assign bus.pending    = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_read_pipe
// Brief  : Directed vector bench for mem_read_pipe (LATENCY 4 and 1 instances).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_read_pipe;

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        ev;
        logic [15:0] ed;
        logic [15:0] ea;
        logic [3:0]  ep;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

`ifdef MEM_WR_FWD_EN
    localparam logic [15:0] FWD_EXP = 16'h00BB;
`else
    localparam logic [15:0] FWD_EXP = 16'h00AA;
`endif

    mem_read_pipe_if bus1();
    mem_read_pipe_if bus2();

    mem_read_pipe #(.ADDR_W(13), .LATENCY(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mem_read_pipe #(.ADDR_W(13), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic en, input logic wr, input logic [15:0] addr,
                                input logic [15:0] din, input logic ev, input logic [15:0] ed,
                                input logic [15:0] ea, input logic [3:0] ep);
        vec_t v;
        v.en = en; v.wr = wr; v.addr = addr; v.din = din;
        v.ev = ev; v.ed = ed; v.ea = ea; v.ep = ep;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        bus1.enable  = v.en;
        bus1.wr      = v.wr;
        bus1.addr    = v.addr;
        bus1.data_in = v.din;
        @(negedge clk);
        chk($sformatf("row%0d data_valid", idx), {15'd0, bus1.data_valid}, {15'd0, v.ev});
        chk($sformatf("row%0d data_out", idx), bus1.data_out, v.ed);
        chk($sformatf("row%0d addr_out", idx), bus1.addr_out, v.ea);
        chk($sformatf("row%0d pending", idx), {12'd0, bus1.pending}, {12'd0, v.ep});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single write then read; write makes no strobe
        add(1, 1, 16'h0040, 16'hBEEF, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 16'h0040, 1);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 16'h0040, 0);
        // Block preload then 8 back-to-back reads
        for (int k = 0; k < 8; k++)
            add(1, 1, 16'h1230 + 16'(2*k), 16'(k+1), 0, 16'hBEEF, 16'h0040, 0);
        add(1, 0, 16'h1230, 0, 0, 16'hBEEF, 16'h0040, 0);
        add(1, 0, 16'h1232, 0, 0, 16'hBEEF, 16'h0040, 1);
        add(1, 0, 16'h1234, 0, 0, 16'hBEEF, 16'h0040, 2);
        add(1, 0, 16'h1236, 0, 0, 16'hBEEF, 16'h0040, 3);
        add(1, 0, 16'h1238, 0, 1, 16'h0001, 16'h1230, 4);
        add(1, 0, 16'h123A, 0, 1, 16'h0002, 16'h1232, 4);
        add(1, 0, 16'h123C, 0, 1, 16'h0003, 16'h1234, 4);
        add(1, 0, 16'h123E, 0, 1, 16'h0004, 16'h1236, 4);
        add(0, 0, 16'h0000, 0, 1, 16'h0005, 16'h1238, 4);
        add(0, 0, 16'h0000, 0, 1, 16'h0006, 16'h123A, 3);
        add(0, 0, 16'h0000, 0, 1, 16'h0007, 16'h123C, 2);
        add(0, 0, 16'h0000, 0, 1, 16'h0008, 16'h123E, 1);
        add(0, 0, 16'h0000, 0, 0, 16'h0008, 16'h123E, 0);
        // Aliasing, ignored write with enable low, odd byte address
        add(1, 1, 16'h4002, 16'h1111, 0, 16'h0008, 16'h123E, 0);
        add(0, 1, 16'h0040, 16'hDEAD, 0, 16'h0008, 16'h123E, 0);
        add(1, 0, 16'h0002, 16'h0000, 0, 16'h0008, 16'h123E, 0);
        add(1, 0, 16'h0041, 16'h0000, 0, 16'h0008, 16'h123E, 1);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0008, 16'h123E, 2);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0008, 16'h123E, 2);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h1111, 16'h0002, 2);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 16'h0040, 1);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 16'h0040, 0);
        // Write to a word whose read is already in flight
        add(1, 1, 16'h0100, 16'h00AA, 0, 16'hBEEF, 16'h0040, 0);
        add(1, 0, 16'h0100, 16'h0000, 0, 16'hBEEF, 16'h0040, 0);
        add(1, 1, 16'h0100, 16'h00BB, 0, 16'hBEEF, 16'h0040, 1);
        add(1, 0, 16'h0100, 16'h0000, 0, 16'hBEEF, 16'h0040, 1);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 16'h0040, 2);
        add(0, 0, 16'h0000, 16'h0000, 1, FWD_EXP,  16'h0100, 2);
        add(0, 0, 16'h0000, 16'h0000, 0, FWD_EXP,  16'h0100, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h00BB, 16'h0100, 1);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h00BB, 16'h0100, 0);

        bus1.enable = 0; bus1.wr = 0; bus1.addr = 0; bus1.data_in = 0;
        bus2.enable = 0; bus2.wr = 0; bus2.addr = 0; bus2.data_in = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // Reset while three reads are in flight
        for (int k = 0; k < 3; k++) begin
            bus1.enable = 1; bus1.wr = 0; bus1.addr = 16'h1230 + 16'(2*k);
            @(posedge clk);
            #1;
        end
        bus1.enable = 0;
        rst = 1'b0;
        #1;
        chk("rst data_valid", {15'd0, bus1.data_valid}, 16'd0);
        chk("rst data_out", bus1.data_out, 16'h0000);
        chk("rst addr_out", bus1.addr_out, 16'h0000);
        chk("rst pending", {12'd0, bus1.pending}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst c%0d data_valid", k), {15'd0, bus1.data_valid}, 16'd0);
            chk($sformatf("post-rst c%0d pending", k), {12'd0, bus1.pending}, 16'd0);
            chk($sformatf("post-rst c%0d data_out", k), bus1.data_out, 16'h0000);
            @(posedge clk);
            #1;
        end

        // LATENCY = 1 instance: five back-to-back reads
        for (int k = 0; k < 5; k++) begin
            bus2.enable = 1; bus2.wr = 1;
            bus2.addr = 16'h0200 + 16'(2*k); bus2.data_in = 16'h0010 + 16'(k);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 7; k++) begin
            logic exp_v;
            if (k < 5) begin
                bus2.enable = 1; bus2.wr = 0; bus2.addr = 16'h0200 + 16'(2*k);
            end else begin
                bus2.enable = 0;
            end
            exp_v = (k >= 1 && k <= 5);
            @(negedge clk);
            chk($sformatf("lat1 c%0d data_valid", k), {15'd0, bus2.data_valid}, {15'd0, exp_v});
            chk($sformatf("lat1 c%0d pending", k), {12'd0, bus2.pending}, {15'd0, exp_v});
            if (exp_v) begin
                chk($sformatf("lat1 c%0d data_out", k), bus2.data_out, 16'h0010 + 16'(k-1));
                chk($sformatf("lat1 c%0d addr_out", k), bus2.addr_out, 16'h0200 + 16'(2*(k-1)));
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_read_pipe.md
Name: mem_read_pipe

Overview:
- Pipelined multicycle main-memory model that sits directly upstream of the cache fill FSM.
- Accepts one word read or write per cycle.
- Returns read data after a fixed latency with a single-cycle data_valid strobe. The fill FSM issues 8 back-to-back word reads per cache block and consumes this strobe as memory_data_valid.
- Backing store is a word-addressed array. The pipeline is a valid/data/address delay line.

Parameters:
- ADDR_W, 13: word-address bits; the array holds 2^ADDR_W 16-bit words.
- LATENCY, 4: read latency in cycles, legal range 1..8.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- enable  input  1  request valid this cycle
- wr  input  1  with enable: 1 = write, 0 = read
- addr  input  16  byte address; bit 0 ignored; bits [ADDR_W:1] index the array; upper bits ignored (aliasing)
- data_in  input  16  write data
- data_out  output  16  read data, meaningful only while data_valid = 1
- data_valid  output  1  one-cycle strobe per completed read
- addr_out  output  16  byte address of the read being delivered, bit 0 forced to 0
- pending  output  4  number of reads in flight, including the one being delivered this cycle

Behaviour:
- Reset (rst = 0, asynchronous):
  - all pipeline valid bits clear; data_out = 0, addr_out = 0, data_valid = 0, pending = 0.
  - Array contents are not reset.
- Request sampling: requests are sampled at the rising edge; there is no stall and no ready signal, so one request is accepted every cycle.
- Write (enable = 1, wr = 1): the array word at the sampled index is updated at that edge. No data_valid and no pipeline entry.
- Read (enable = 1, wr = 0):
  - array is read at the sampling edge; data and address enter stage 1.
  - Data reflects all writes sampled on earlier edges.
- Latency: a read sampled at edge t has data_valid = 1 for exactly the cycle after edge t+LATENCY-1. With LATENCY = 4, a request driven in cycle 0 is delivered in cycle 4.
- Throughput and ordering: N consecutive reads give N consecutive data_valid cycles, in issue order, with no gaps and no reordering.
- Stage advance: every stage shifts every cycle. A stage whose valid bit is 0 carries don't-care data; data_out is held at its last delivered value when idle.
- pending counter:
  - +1 on each read accepted, -1 on the edge that retires a delivered read; both in the same edge leaves it unchanged.
  - Never exceeds LATENCY.
- enable = 0: no array or pipeline effect; wr and data_in are ignored.
- Reset mid-operation: every in-flight read is discarded; no data_valid for it after reset deasserts.
- Read and write to the same word on consecutive edges: the read sees the written value.
- Behaviour is identical for all LATENCY values except the delay-line depth.

Optional Feature:
- Macro MEM_WR_FWD_EN.
- Defined: a write sampled while a read to the same word index is in flight also overwrites that in-flight entry's data. The delivered data then equals the latest array value at delivery time, and it applies to every matching stage.
- Undefined: in-flight data is frozen at issue, so a later write is not visible to an earlier-issued read.

Decomposition:
- Shared package:
  - WORD_W = 16
  - default LATENCY = 4
  - BLOCK_WORDS = 8
  - a typedef for the pipeline entry struct {valid, addr[15:0], data[15:0]}
- Sub-module mem_pipe_stage: one delay-line register holding valid/addr/data with asynchronous active-low reset and the optional forward-write compare. It is instantiated LATENCY times.

Test Plan:
- Write 0xBEEF to 0x0040, then read 0x0040 on the next edge (LATENCY = 4) -> data_valid only in issue+4, data_out = 0xBEEF, addr_out = 0x0040, pending peaks at 1. The write itself produces no strobe.
- Preload words 0x1230..0x123E with 0x0001..0x0008, then issue 8 back-to-back reads -> 8 consecutive data_valid cycles delivering 0x0001..0x0008 in order, pending = 4 at steady state, then falls to 0.
- Issue 3 reads, pull rst low for 1 cycle before the first delivery -> no data_valid ever, pending = 0, data_out = 0, data_out/addr_out = 0.
- ADDR_W = 13: write 0x1111 to 0x4002, then read 0x0002 -> returns 0x1111 (aliasing).
- Read 0x0100 (holds 0x00AA), then write 0x00BB to 0x0100 one edge later -> delivers 0x00AA without MEM_WR_FWD_EN, 0x00BB with it.
- LATENCY = 1: a read in every cycle for 5 cycles -> data_valid high cycles 1..5, pending never exceeds 1.
